// File: rtl/uop_issue_queue_pkg.sv
// Shared backend definitions for the uop issue queue: widths, payload struct,
// queue FSM states and the saturating counter helper.
package uop_issue_queue_pkg;

    localparam int NUM_UOPS      = 128;
    localparam int XLEN          = 32;
    localparam int ARCHFILE_SIZE = 16;
    localparam int QDEPTH        = 8;

    localparam int UOP_W  = $clog2(NUM_UOPS);
    localparam int ARCH_W = $clog2(ARCHFILE_SIZE);
    localparam int PC_W   = 32;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FENCE = 1'b1
    } q_state_e;

    typedef struct packed {
        logic [UOP_W-1:0]  uop;
        logic              eoi;
        logic [XLEN-1:0]   imm;
        logic              use_imm;
        logic [PC_W-1:0]   pc;
        logic              except;
        logic [ARCH_W-1:0] src1_arch;
        logic [ARCH_W-1:0] src2_arch;
        logic [ARCH_W-1:0] dest_arch;
    } uop_payload_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/uop_issue_queue_if.sv
// Decode-to-queue intake and queue-to-backend uop bus. The queue uses the
// slave modport; the producer/consumer environment uses master.
interface uop_issue_queue_if;
    import uop_issue_queue_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [UOP_W-1:0]  in_uop;
    logic              in_eoi;
    logic [XLEN-1:0]   in_imm;
    logic              in_use_imm;
    logic [PC_W-1:0]   in_pc;
    logic              in_except;
    logic [ARCH_W-1:0] in_src1_arch;
    logic [ARCH_W-1:0] in_src2_arch;
    logic [ARCH_W-1:0] in_dest_arch;

    logic              be_stall;
    logic              uop_ready;
    logic [UOP_W-1:0]  uop;
    logic              eoi;
    logic [XLEN-1:0]   imm;
    logic              use_imm;
    logic [PC_W-1:0]   pc;
    logic              except;
    logic [ARCH_W-1:0] src1_arch;
    logic [ARCH_W-1:0] src2_arch;
    logic [ARCH_W-1:0] dest_arch;

    modport slave (
        input  in_valid, in_uop, in_eoi, in_imm, in_use_imm, in_pc, in_except,
               in_src1_arch, in_src2_arch, in_dest_arch, be_stall,
        output in_ready, uop_ready, uop, eoi, imm, use_imm, pc, except,
               src1_arch, src2_arch, dest_arch
    );

    modport master (
        output in_valid, in_uop, in_eoi, in_imm, in_use_imm, in_pc, in_except,
               in_src1_arch, in_src2_arch, in_dest_arch, be_stall,
        input  in_ready, uop_ready, uop, eoi, imm, use_imm, pc, except,
               src1_arch, src2_arch, dest_arch
    );

endinterface

// File: rtl/uopq_fifo_mem.sv
// DEPTH x payload register array: one synchronous write port, one
// combinational read port. Contents are not reset; the owner masks by count.
module uopq_fifo_mem
    import uop_issue_queue_pkg::*;
#(
    parameter int DEPTH = QDEPTH
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  uop_payload_t             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output uop_payload_t             rdata_o
);

    uop_payload_t mem_q [DEPTH];

    // write port
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/uop_issue_queue.sv
// Uop issue queue: buffers decoded uops and presents the head to the backend,
// fencing intake after an excepting uop until flush. Optional counters: UOPQ_STATS_EN.
module uop_issue_queue
    import uop_issue_queue_pkg::*;
#(
    parameter int DEPTH = QDEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
`ifdef UOPQ_STATS_EN
    output logic [31:0]        issued_cnt,
    output logic [31:0]        stall_cnt,
`endif
    uop_issue_queue_if.slave   q_if
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    q_state_e           state_q, state_d;
    logic [PTR_W-1:0]   head_q, head_d;
    logic [PTR_W-1:0]   tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               in_ready_s;
    logic               uop_ready_s;
    logic               enq_s;
    logic               deq_s;
    uop_payload_t       wdata_s;
    uop_payload_t       rdata_s;
    uop_payload_t       head_s;

    // A full queue refuses intake even if the head leaves this cycle.
    assign in_ready_s  = !rst && (state_q == RUN) && (count_q != CNT_W'(DEPTH));
    assign uop_ready_s = (count_q != {CNT_W{1'b0}});
    assign enq_s       = q_if.in_valid && in_ready_s;
    assign deq_s       = uop_ready_s && !q_if.be_stall;

    assign wdata_s = '{
        uop:       q_if.in_uop,
        eoi:       q_if.in_eoi,
        imm:       q_if.in_imm,
        use_imm:   q_if.in_use_imm,
        pc:        q_if.in_pc,
        except:    q_if.in_except,
        src1_arch: q_if.in_src1_arch,
        src2_arch: q_if.in_src2_arch,
        dest_arch: q_if.in_dest_arch
    };

    uopq_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .we_i    (enq_s),
        .waddr_i (tail_q),
        .wdata_i (wdata_s),
        .raddr_i (head_q),
        .rdata_o (rdata_s)
    );

    assign head_s = uop_ready_s ? rdata_s : '0;

    assign q_if.in_ready  = in_ready_s;
    assign q_if.uop_ready = uop_ready_s;
    assign q_if.uop       = head_s.uop;
    assign q_if.eoi       = head_s.eoi;
    assign q_if.imm       = head_s.imm;
    assign q_if.use_imm   = head_s.use_imm;
    assign q_if.pc        = head_s.pc;
    assign q_if.except    = head_s.except;
    assign q_if.src1_arch = head_s.src1_arch;
    assign q_if.src2_arch = head_s.src2_arch;
    assign q_if.dest_arch = head_s.dest_arch;

    // next-state for pointers, occupancy and fence FSM; flush overrides everything
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            state_d = RUN;
            head_d  = {PTR_W{1'b0}};
            tail_d  = {PTR_W{1'b0}};
            count_d = {CNT_W{1'b0}};
        end else begin
            if (enq_s) begin
                tail_d = tail_q + PTR_W'(1);
            end else begin
                tail_d = tail_q;
            end
            if (deq_s) begin
                head_d = head_q + PTR_W'(1);
            end else begin
                head_d = head_q;
            end
            case ({enq_s, deq_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
            case (state_q)
                RUN: begin
                    if (enq_s && q_if.in_except) begin
                        state_d = FENCE;
                    end else begin
                        state_d = RUN;
                    end
                end
                FENCE:   state_d = FENCE;
                default: state_d = RUN;
            endcase
        end
    end

    // state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            head_q  <= {PTR_W{1'b0}};
            tail_q  <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

`ifdef UOPQ_STATS_EN
    // Counters survive flush; a dequeue in a flush cycle is discarded, so it is not counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            issued_cnt <= 32'd0;
            stall_cnt  <= 32'd0;
        end else begin
            if (deq_s && !flush) begin
                issued_cnt <= sat_inc32(issued_cnt);
            end else begin
                issued_cnt <= issued_cnt;
            end
            if (uop_ready_s && q_if.be_stall) begin
                stall_cnt <= sat_inc32(stall_cnt);
            end else begin
                stall_cnt <= stall_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uop_issue_queue.sv
// Self-checking bench for uop_issue_queue: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_uop_issue_queue;
    import uop_issue_queue_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic flush;
`ifdef UOPQ_STATS_EN
    logic [31:0] issued_cnt;
    logic [31:0] stall_cnt;
    int unsigned m_issued;
    int unsigned m_stalls;
`endif

    uop_issue_queue_if bus ();

    uop_issue_queue dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
`ifdef UOPQ_STATS_EN
        .issued_cnt (issued_cnt),
        .stall_cnt  (stall_cnt),
`endif
        .q_if       (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    uop_payload_t model_q[$];
    bit           model_fence;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: drive at negedge, compare against the model, then advance the model.
    task automatic step(input logic v, input logic ex, input logic st, input logic fl,
                        input logic r, input logic [31:0] pcv, input logic [6:0] uv,
                        input logic [31:0] iv, input logic ui);
        uop_payload_t p, exp_p, got_p;
        bit exp_in_ready;
        @(negedge clk);
        p.uop       = uv;
        p.eoi       = 1'($urandom_range(1));
        p.imm       = iv;
        p.use_imm   = ui;
        p.pc        = pcv;
        p.except    = ex;
        p.src1_arch = 4'($urandom_range(15));
        p.src2_arch = 4'($urandom_range(15));
        p.dest_arch = 4'($urandom_range(15));
        bus.in_valid     = v;
        bus.in_uop       = p.uop;
        bus.in_eoi       = p.eoi;
        bus.in_imm       = p.imm;
        bus.in_use_imm   = p.use_imm;
        bus.in_pc        = p.pc;
        bus.in_except    = p.except;
        bus.in_src1_arch = p.src1_arch;
        bus.in_src2_arch = p.src2_arch;
        bus.in_dest_arch = p.dest_arch;
        bus.be_stall     = st;
        flush            = fl;
        rst              = r;
        #1;
        exp_in_ready = !r && !model_fence && (model_q.size() < QDEPTH);
        exp_p = (model_q.size() != 0) ? model_q[0] : '0;
        got_p = '{uop: bus.uop, eoi: bus.eoi, imm: bus.imm, use_imm: bus.use_imm,
                  pc: bus.pc, except: bus.except, src1_arch: bus.src1_arch,
                  src2_arch: bus.src2_arch, dest_arch: bus.dest_arch};
        check_eq("in_ready", 128'(bus.in_ready), 128'(exp_in_ready));
        check_eq("uop_ready", 128'(bus.uop_ready), 128'(model_q.size() != 0));
        check_eq("payload", 128'(got_p), 128'(exp_p));
`ifdef UOPQ_STATS_EN
        check_eq("issued_cnt", 128'(issued_cnt), 128'(m_issued));
        check_eq("stall_cnt", 128'(stall_cnt), 128'(m_stalls));
`endif
        @(posedge clk);
`ifdef UOPQ_STATS_EN
        if (r) begin
            m_issued = 0;
            m_stalls = 0;
        end else begin
            if (model_q.size() != 0 && st) m_stalls++;
            if (model_q.size() != 0 && !st && !fl) m_issued++;
        end
`endif
        if (r || fl) begin
            model_q.delete();
            model_fence = 1'b0;
        end else begin
            if (model_q.size() != 0 && !st) void'(model_q.pop_front());
            if (v && exp_in_ready) begin
                model_q.push_back(p);
                if (ex) model_fence = 1'b1;
            end
        end
    endtask

    task automatic idle(input logic st);
        step(1'b0, 1'b0, st, 1'b0, 1'b0, 32'h0, 7'h0, 32'h0, 1'b0);
    endtask

    task automatic enq(input logic ex, input logic st, input logic [31:0] pcv);
        step(1'b1, ex, st, 1'b0, 1'b0, pcv, 7'($urandom_range(127)), $urandom, 1'b0);
    endtask

    initial begin
        model_fence = 1'b0;
`ifdef UOPQ_STATS_EN
        m_issued = 0;
        m_stalls = 0;
`endif
        bus.in_valid = 1'b0;
        bus.be_stall = 1'b0;
        flush = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // reset state, then single uop with one-cycle latency and empty afterwards
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 7'h0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h10, 7'b0100000, 32'h1, 1'b1);
        idle(1'b0);
        idle(1'b0);

        // fill under stall, refused when full, then drain on consecutive cycles
        for (int i = 0; i < 8; i++) enq(1'b0, 1'b1, 32'(i));
        repeat (2) enq(1'b0, 1'b1, 32'h99);
        repeat (9) idle(1'b0);

        // full with dequeue in same cycle: no enqueue, resumes next cycle
        for (int i = 0; i < 8; i++) enq(1'b0, 1'b1, 32'(i + 16));
        enq(1'b0, 1'b0, 32'h50);
        enq(1'b0, 1'b1, 32'h51);
        enq(1'b0, 1'b1, 32'h52);
        repeat (9) idle(1'b0);

        // fence after an excepting uop, drain, then flush reopens intake
        enq(1'b1, 1'b0, 32'h20);
        enq(1'b0, 1'b0, 32'h24);
        idle(1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 7'h0, 32'h0, 1'b0);
        idle(1'b0);

        // flush with simultaneous enqueue and dequeue discards both
        enq(1'b0, 1'b1, 32'h30);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h34, 7'h5, 32'h0, 1'b0);
        idle(1'b0);

`ifdef UOPQ_STATS_EN
        // counters: stalls then issues, flush keeps them, rst clears them
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 7'h0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) enq(1'b0, 1'b1, 32'(i));
        repeat (3) idle(1'b1);
        repeat (6) idle(1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 7'h0, 32'h0, 1'b0);
        idle(1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 7'h0, 32'h0, 1'b0);
        idle(1'b0);
`endif

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(99) < 70),
                 1'($urandom_range(99) < 3),
                 1'($urandom_range(99) < 40),
                 1'($urandom_range(99) < 3),
                 1'($urandom_range(199) < 1),
                 $urandom, 7'($urandom_range(127)), $urandom,
                 1'($urandom_range(1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uop_issue_queue.md
Name: uop_issue_queue

Overview:
- Frontend-side producer of the backend uop interface. It drives uop_ready, uop, eoi, imm, use_imm, pc, except, src1_arch, src2_arch and dest_arch into backend_TOP.
- Buffers decoded uops from decode in a small FIFO and presents the head entry to the backend. Holds the head stable while the backend stalls.
- Fences further intake after an excepting uop until flush.

Parameters:
- NUM_UOPS, 128, uop opcode space; uop width = $clog2(NUM_UOPS)
- XLEN, 32, immediate width
- ARCHFILE_SIZE, 16, architectural registers; arch index width = $clog2(ARCHFILE_SIZE)
- DEPTH, 8, FIFO entries; must be a power of 2 and ≥2

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all entries, leave FENCE
- in_valid  in  1  decode presents a uop
- in_ready  out  1  queue accepts a uop this cycle
- in_uop  in  $clog2(NUM_UOPS)  opcode
- in_eoi  in  1  last uop of instruction
- in_imm  in  XLEN  immediate
- in_use_imm  in  1  src2 replaced by immediate
- in_pc  in  32  instruction PC
- in_except  in  1  uop carries exception
- in_src1_arch, in_src2_arch, in_dest_arch  in  $clog2(ARCHFILE_SIZE) each  register indices
- be_stall  in  1  backend cannot accept this cycle
- uop_ready  out  1  head entry valid
- uop, eoi, imm, use_imm, pc, except, src1_arch, src2_arch, dest_arch  out  same widths as in_*  head entry payload

Behaviour:
- Storage: DEPTH-entry array. head and tail pointers are $clog2(DEPTH) bits and wrap naturally. count is $clog2(DEPTH)+1 bits.
- Enqueue when in_valid && in_ready. Dequeue when uop_ready && !be_stall.
- in_ready = !rst && state==RUN && count!=DEPTH. A full queue does not accept even if a dequeue occurs in the same cycle.
- uop_ready = (count!=0). The payload is a combinational read of the head entry and is forced to all-zero when empty.
- Latency: a uop enqueued in cycle N appears on the outputs in cycle N+1 at the earliest. There is no same-cycle bypass.
- Payload and uop_ready stay stable while be_stall=1.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- FSM states: RUN, FENCE.
  - RUN→FENCE when a uop with in_except=1 is enqueued. That uop is stored; later uops are refused.
  - FENCE→RUN on flush.
  - The queue keeps draining to the backend while in FENCE.
- Flush: next cycle count=0, head=tail=0, state=RUN.
  - Any enqueue or dequeue in the flush cycle is discarded.
  - flush dominates all other events.
- Reset: next cycle count=0, pointers=0, state=RUN, uop_ready=0, all payload outputs 0. in_ready=0 while rst is high.
- Reset mid-operation drops all contents, same as flush.
- Storage contents need no reset; they are masked by count.

Optional Feature:
- Macro: UOPQ_STATS_EN.
- When defined, adds 32-bit outputs issued_cnt and stall_cnt.
  - issued_cnt increments on every dequeue.
  - stall_cnt increments on every cycle with uop_ready && be_stall.
  - Both clear on rst only (not on flush) and saturate at 2^32-1.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared backend package holds:
  - the uop payload struct typedef (uop, eoi, imm, use_imm, pc, except, src1/src2/dest arch)
  - the FSM state enum (RUN, FENCE)
  - width localparams derived from NUM_UOPS/XLEN/ARCHFILE_SIZE.
- One natural sub-module: uopq_fifo_mem, a DEPTH×payload register array with one write port and one combinational read port. Pointer, count and FSM logic stay in the top.

Test Plan:
- Reset, then enqueue uop=7'b0100000, imm=1, use_imm=1, pc=0x10, be_stall=0 → next cycle uop_ready=1 with those values; following cycle uop_ready=0 and payload all zero.
- Hold be_stall=1, enqueue 8 uops with pc=0..7 → in_ready=0 after the 8th; count=8; outputs show pc=0 unchanged throughout. Release stall → pc 0..7 issue on 8 consecutive cycles.
- Queue full with in_valid=1 and a dequeue in the same cycle → no enqueue that cycle; enqueue resumes the next cycle; count=7 then 8.
- Enqueue pc=0x20 with except=1, then pc=0x24 → pc=0x24 refused (in_ready=0); pc=0x20 still issues; assert flush → next cycle in_ready=1, uop_ready=0.
- Flush asserted together with in_valid and a dequeue → queue empty next cycle; neither uop is counted as accepted or issued.
- With UOPQ_STATS_EN: 3 stall cycles then 5 issues → stall_cnt=3, issued_cnt=5; flush leaves both unchanged; rst clears both.
